regfile_port_ctrl: RTL and testbench
====================================

REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 2, meaning the number of pending-write buffer entries (legal values 2..4).
REQ-002 SHALL have parameter ZERO_R0, default 1, meaning register 0 reads as zero and writes to it are dropped.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports wr_valid (input, 1), wr_ready (output, 1), wr_addr (input, 5), wr_data (input, 32): the write request channel.
REQ-006 SHALL have ports rd_valid (input, 1), rd_ready (output, 1), rd_addr_a (input, 5), rd_addr_b (input, 5): the read request channel.
REQ-007 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data_a (output, 32), rsp_data_b (output, 32): the read response channel.
REQ-008 SHALL have ports write_sl (output, 32, one-hot or zero), wdata (output, 32), select_a (output, 32), select_b (output, 32): the array drive side.
REQ-009 SHALL have ports outA (input, 32) and outB (input, 32): combinational read data from the 32x32 array.

Function
REQ-010 SHALL transfer a request on a channel only in a cycle where valid and ready are both high at the rising clk edge.
REQ-011 SHALL hold accepted writes in an in-order FIFO of WBUF_DEPTH entries; wr_ready SHALL equal (count < WBUF_DEPTH), with no same-cycle pass-through when full.
REQ-012 SHALL, whenever the FIFO is non-empty, drive write_sl = onehot(head.addr) and wdata = head.data, and pop the head at the next edge (one retire per cycle).
REQ-013 SHALL drive write_sl = 0 when the FIFO is empty, or when the head address is 0 and ZERO_R0 = 1 (the entry is still popped).
REQ-014 SHALL support a simultaneous push and pop: count unchanged, and the new entry lands at the tail.
REQ-015 SHALL drive rd_ready = !rsp_valid || rsp_ready.
REQ-016 SHALL drive select_a = onehot(rd_addr_a) and select_b = onehot(rd_addr_b) while rd_valid && rd_ready, and 0 otherwise.
REQ-017 SHALL register the read result at the acceptance edge: rsp_valid rises the cycle after acceptance (latency 1), and rsp_data holds until the response is taken.
REQ-018 SHALL, per read port, return the data of the youngest FIFO entry matching the address (including the entry retiring that cycle) instead of outA/outB.
REQ-019 SHALL NOT forward from a write accepted in the same cycle as the read; that read returns the prior value.
REQ-020 SHALL return 0 for address 0 when ZERO_R0 = 1, regardless of the FIFO or the array.
REQ-021 SHALL clear rsp_valid on an edge where rsp_valid && rsp_ready and no new read is accepted; back-to-back reads SHALL sustain one response per cycle.

Reset
REQ-022 SHALL, while rst_n = 0, force the FIFO count to 0, rsp_valid = 0, rsp_data_a/b = 0, and write_sl/select_a/select_b = 0 asynchronously.
REQ-023 SHALL discard all pending writes on reset mid-drain; they are never written to the array.
REQ-024 SHALL deassert reset synchronously to clk, with wr_ready = 1 and rd_ready = 1 in the first cycle after release.

Verification
REQ-025 SHALL cover: write r5 = 0xDEADBEEF, idle 3 cycles, then read a = 5, b = 0 -> write_sl = 0x00000020 for one cycle; the response is a = 0xDEADBEEF, b = 0x0 one cycle after acceptance.
REQ-026 SHALL cover: three back-to-back writes with WBUF_DEPTH = 2 and no drain stall -> wr_ready stays 1; with the FIFO full, wr_ready = 0 and the third write waits one cycle.
REQ-027 SHALL cover: write r7 = 0x1, then write r7 = 0x2, then read r7 on the port-A read address in the next cycle -> rsp_data_a = 0x2 (youngest forwarded).
REQ-028 SHALL cover: a write to r3 and a read of r3 accepted in the same cycle with the old value 0x0 -> rsp_data_a = 0x0, and a later read returns the new value.
REQ-029 SHALL cover: rsp_ready held low for 4 cycles with rd_valid high -> rd_ready = 0, and rsp_data stays stable until the response is taken.
REQ-030 SHALL cover: rst_n pulsed low with 2 writes pending -> write_sl = 0 immediately, count = 0, and later reads return the pre-write array values.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_port_ctrl: write-buffered, forwarding port controller for a 32x32 |
// | register array.                                        Revision: 1.0      |
// +--------------------------------------------------------------------------+
module regfile_port_ctrl #(
  parameter int WBUF_DEPTH = 2,
  parameter bit ZERO_R0    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data_a,
  output logic [31:0] rsp_data_b,
  output logic [31:0] write_sl,
  output logic [31:0] wdata,
  output logic [31:0] select_a,
  output logic [31:0] select_b,
  input  logic [31:0] outA,
  input  logic [31:0] outB
);
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  logic [4:0]       addr_q [WBUF_DEPTH];
  logic [4:0]       addr_d [WBUF_DEPTH];
  logic [31:0]      data_q [WBUF_DEPTH];
  logic [31:0]      data_d [WBUF_DEPTH];
  logic [CNT_W-1:0] count_q, count_d, wr_idx;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
  logic [31:0]      fwd_a, fwd_b;
  logic             push, pop, rd_fire;

  function automatic logic [31:0] onehot(input logic [4:0] a);
    onehot = 32'd1 << a;
  endfunction

  assign wr_ready = (count_q < CNT_W'(WBUF_DEPTH));
  assign pop      = (count_q != '0);
  assign push     = wr_valid && wr_ready;
  assign rd_ready = !rsp_valid_q || rsp_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_idx   = pop ? (count_q - {{(CNT_W-1){1'b0}}, 1'b1}) : count_q;

  // Entry 0 is always the head, so it is the one driving the array.
  assign write_sl = (pop && !(ZERO_R0 && addr_q[0] == 5'd0)) ? onehot(addr_q[0]) : '0;
  assign wdata    = data_q[0];
  assign select_a = (rst_n && rd_fire) ? onehot(rd_addr_a) : '0;
  assign select_b = (rst_n && rd_fire) ? onehot(rd_addr_b) : '0;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data_a = rsp_a_q;
  assign rsp_data_b = rsp_b_q;

  // Ascending scan: a later (younger) match overrides an older one.
  always_comb begin
    fwd_a = outA;
    fwd_b = outB;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if (addr_q[i] == rd_addr_a) fwd_a = data_q[i];
        if (addr_q[i] == rd_addr_b) fwd_b = data_q[i];
      end
    end
    if (ZERO_R0 && rd_addr_a == 5'd0) fwd_a = '0;
    if (ZERO_R0 && rd_addr_b == 5'd0) fwd_b = '0;
  end

  always_comb begin
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
    end
    if (pop) begin
      for (int i = 0; i < WBUF_DEPTH - 1; i++) begin
        addr_d[i] = addr_q[i+1];
        data_d[i] = data_q[i+1];
      end
    end
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (push && CNT_W'(i) == wr_idx) begin
        addr_d[i] = wr_addr;
        data_d[i] = wr_data;
      end
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
      rsp_a_d     = fwd_a;
      rsp_b_d     = fwd_b;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_port_ctrl: bench for regfile_port_ctrl with a 32x32 array      |
// | model and a logical register-file reference.           Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_regfile_port_ctrl;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_valid = 1'b0, rd_ready;
  logic [4:0]  rd_addr_a = '0, rd_addr_b = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_data_a, rsp_data_b;
  logic [31:0] write_sl, wdata, select_a, select_b;
  logic [31:0] outA, outB;

  regfile_port_ctrl #(.WBUF_DEPTH(D), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .write_sl(write_sl), .wdata(wdata), .select_a(select_a), .select_b(select_b),
    .outA(outA), .outB(outB)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 3) return 32'h0;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // Register array environment, driven only through write_sl/wdata and select_a/b.
  logic [31:0] mem [32];
  logic        env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      env_init <= 1'b1;
    end else begin
      for (int i = 0; i < 32; i++) if (write_sl[i]) mem[i] <= wdata;
    end
  end

  always_comb begin
    outA = '0;
    outB = '0;
    for (int i = 0; i < 32; i++) begin
      if (select_a[i]) outA = outA | mem[i];
      if (select_b[i]) outB = outB | mem[i];
    end
  end

  // Reference: logical register view (updated at write acceptance), committed
  // array view, and the queue of accepted-but-not-yet-retired writes.
  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  logic [31:0] ref_r [32];
  logic [31:0] com_r [32];
  wr_t         pend [$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_a = '0, exp_b = '0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic        wa, ra;
    logic [31:0] exp_sl;
    wr_t         e;
    #1;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, pend.size() < D});
    chk("rd_ready", {31'd0, rd_ready}, {31'd0, !exp_valid || rsp_ready});
    exp_sl = '0;
    if (pend.size() != 0 && pend[0].a != 5'd0) exp_sl = 32'd1 << pend[0].a;
    chk("write_sl", write_sl, exp_sl);
    if (exp_sl != 0) chk("wdata", wdata, pend[0].d);
    ra = rd_valid && (!exp_valid || rsp_ready);
    wa = wr_valid && (pend.size() < D);
    chk("select_a", select_a, ra ? (32'd1 << rd_addr_a) : 32'd0);
    chk("select_b", select_b, ra ? (32'd1 << rd_addr_b) : 32'd0);
    @(posedge clk);
    if (ra) begin
      exp_valid = 1'b1;
      exp_a = (rd_addr_a == 5'd0) ? 32'd0 : ref_r[rd_addr_a];
      exp_b = (rd_addr_b == 5'd0) ? 32'd0 : ref_r[rd_addr_b];
    end else if (rsp_ready) begin
      exp_valid = 1'b0;
    end
    if (pend.size() != 0) begin
      e = pend.pop_front();
      if (e.a != 5'd0) com_r[e.a] = e.d;
    end
    if (wa) begin
      pend.push_back('{a: wr_addr, d: wr_data});
      if (wr_addr != 5'd0) ref_r[wr_addr] = wr_data;
    end
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
    chk("rsp_data_a", rsp_data_a, exp_a);
    chk("rsp_data_b", rsp_data_b, exp_b);
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [4:0] ra, input logic [4:0] rb,
                       input logic rr);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr_a = ra; rd_addr_b = rb;
    rsp_ready = rr;
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
  endtask

  // Entered at a negedge; asserts reset mid-cycle, releases on a later negedge.
  task automatic do_reset();
    rd_valid = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd6; wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst write_sl", write_sl, 32'd0);
    chk("rst select_a", select_a, 32'd0);
    chk("rst select_b", select_b, 32'd0);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_data_a", rsp_data_a, 32'd0);
    chk("rst rsp_data_b", rsp_data_b, 32'd0);
    pend.delete();
    ref_r = com_r;
    exp_valid = 1'b0; exp_a = '0; exp_b = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_r[i] = init_val(i);
      com_r[i] = init_val(i);
    end
    @(negedge clk);
    chk("init write_sl", write_sl, 32'd0);
    chk("init rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("init rsp_data_a", rsp_data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write r5, idle, then read a=5 b=0
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b1);
    chk("r5 write_sl", write_sl, 32'h0000_0020);
    idle(); idle(); idle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b1);
    chk("r5 rsp_a", rsp_data_a, 32'hDEADBEEF);
    chk("r5 rsp_b", rsp_data_b, 32'h0);

    // Three back-to-back writes
    drive(1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 5'd0, 1'b1);
    drive(1'b1, 5'd2, 32'hB2, 1'b0, 5'd0, 5'd0, 1'b1);
    drive(1'b1, 5'd4, 32'hC4, 1'b0, 5'd0, 5'd0, 1'b1);
    idle();

    // Youngest forwarding of r7
    drive(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 5'd0, 1'b1);
    drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 1'b1);
    chk("r7 youngest", rsp_data_a, 32'h2);
    idle();

    // Same-cycle write and read of r3: no forwarding, then new value
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd1, 1'b1);
    chk("r3 old", rsp_data_a, 32'h0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd2, 1'b1);
    chk("r3 new", rsp_data_a, 32'h33);
    idle();

    // Response back-pressure for 4 cycles
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd4, 32'h4400 + 32'(k), 1'b1, 5'(k + 1), 5'd4, 1'b0);
      chk("bp rsp_a hold", rsp_data_a, 32'hC4);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0, 1'b1);
    idle();

    // Reset with writes outstanding: r9 retires, r10 is discarded
    drive(1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 5'd0, 1'b1);
    drive(1'b1, 5'd10, 32'hAAAA, 1'b0, 5'd0, 5'd0, 1'b1);
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd9, 1'b1);
    chk("rst r10 pre-write", rsp_data_a, init_val(10));
    chk("rst r9 retired", rsp_data_b, 32'h9999);
    idle();

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0));
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
